alu_mul_sequencer: RTL and testbench

// - Multi-cycle unsigned WORD_SIZE x WORD_SIZE -> 2*WORD_SIZE multiplier built on the shared arithmetic_logic_unit.
// - Performs shift-and-add, one ALU_ADD per iteration; requests the ALU per cycle and advances only when granted.
// - Sits beside the execute stage; the core's ALU input mux selects this block's drive when alu_gnt=1.

---
 rtl/alu_mul_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_pkg: shared ALU operation and flag types used by the core's
// arithmetic_logic_unit and its clients.
//
// alu_mul_sequencer: multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH
// shift-and-add multiplier that borrows the shared ALU for one ALU_ADD per
// iteration.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_valid/start_ready     operand handshake (ready only in IDLE)
//   op_a, op_b                  multiplicand, multiplier (sampled on accept)
//   alu_req/alu_gnt             shared ALU request / grant
//   alu_in_a/alu_in_b/alu_op    drive towards the ALU
//   alu_out/alu_flags           ALU result and flags (only carry consumed)
//   result_valid/result_ready   product handshake
//   product, prod_zero, prod_wide  {hi,lo} product and its status bits
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operands, start_ready=1
// RUN   | one shift-and-add per granted cycle, alu_req=1
// DONE  | product presented until result_ready

package alu_pkg;
  localparam int WORD_SIZE = 16;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASS
  } ALU_OPS_T;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } FLAGS_T;
endpackage

module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               alu_req,
  input  logic               alu_gnt,
  output logic [WIDTH-1:0]   alu_in_a,
  output logic [WIDTH-1:0]   alu_in_b,
  output ALU_OPS_T           alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  input  FLAGS_T             alu_flags,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               prod_zero,
  output logic               prod_wide
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic [CNT_W-1:0] cnt;
  logic             zero_q, wide_q;

  logic             accept, step, last, release_done;
  logic [2*WIDTH-1:0] next_acc;

  // Only the carry flag takes part in the arithmetic.
  logic unused_flags;
  assign unused_flags = ^{alu_flags.overflow, alu_flags.zero, alu_flags.negative};

  // The ALU's carry is bit WIDTH of the partial sum; it becomes the new MSB
  // of the accumulator as the whole pair shifts right by one.
  assign next_acc = {alu_flags.carry, alu_out, acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_ready  = 1'b0;
    alu_req      = 1'b0;
    result_valid = 1'b0;
    alu_in_a     = '0;
    alu_in_b     = '0;
    alu_op       = ALU_ADD;
    accept       = 1'b0;
    step         = 1'b0;
    last         = 1'b0;
    release_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        alu_req  = 1'b1;
        alu_in_a = acc_hi;
        alu_in_b = acc_lo[0] ? mcand : '0;
        if (alu_gnt) begin
          step = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            last    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          release_done = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      cnt    <= '0;
      zero_q <= 1'b0;
      wide_q <= 1'b0;
    end else begin
      if (accept) begin
        mcand  <= op_a;
        acc_lo <= op_b;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (step) begin
        {acc_hi, acc_lo} <= next_acc;
        cnt              <= cnt + 1'b1;
        if (last) begin
          zero_q <= (next_acc == '0);
          wide_q <= (next_acc[2*WIDTH-1:WIDTH] != '0);
        end
      end else if (release_done) begin
        zero_q <= 1'b0;
        wide_q <= 1'b0;
      end
    end
  end

  // Accumulator contents are only exposed once complete.
  assign product   = (state_q == S_DONE) ? {acc_hi, acc_lo} : '0;
  assign prod_zero = zero_q;
  assign prod_wide = wide_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer: emulates the shared ALU, drives directed
// and random operands with varied grant patterns and result back-pressure,
// and compares against plain multiplication.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_valid, start_ready;
  logic [W-1:0]   op_a, op_b;
  logic           alu_req, alu_gnt;
  logic [W-1:0]   alu_in_a, alu_in_b, alu_out;
  ALU_OPS_T       alu_op;
  FLAGS_T         alu_flags;
  logic           result_valid, result_ready;
  logic [2*W-1:0] product;
  logic           prod_zero, prod_wide;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .alu_req      (alu_req),
    .alu_gnt      (alu_gnt),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .product      (product),
    .prod_zero    (prod_zero),
    .prod_wide    (prod_wide)
  );

  // Shared ALU stand-in: unsigned add with carry out; unused flags are
  // driven with junk so that any dependence on them shows up.
  logic [W:0] alu_sum;
  assign alu_sum = {1'b0, alu_in_a} + {1'b0, alu_in_b};
  assign alu_out = alu_sum[W-1:0];
  always_comb begin
    alu_flags          = '0;
    alu_flags.carry    = alu_sum[W];
    alu_flags.overflow = 1'b1;
    alu_flags.zero     = ~alu_sum[0];
    alu_flags.negative = alu_sum[W-1];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string ctx);
    check_val({ctx, "_start_ready"}, 64'(start_ready), 64'd1);
    check_val({ctx, "_alu_req"}, 64'(alu_req), 64'd0);
    check_val({ctx, "_result_valid"}, 64'(result_valid), 64'd0);
    check_val({ctx, "_product"}, 64'(product), 64'd0);
    check_val({ctx, "_prod_zero"}, 64'(prod_zero), 64'd0);
    check_val({ctx, "_prod_wide"}, 64'(prod_wide), 64'd0);
    check_val({ctx, "_alu_in_a"}, 64'(alu_in_a), 64'd0);
    check_val({ctx, "_alu_in_b"}, 64'(alu_in_b), 64'd0);
    check_val({ctx, "_alu_op"}, 64'(alu_op), 64'(ALU_ADD));
  endtask

  // Called at a negedge with the block in IDLE. gmode: 0 grant always,
  // 1 grant toggling starting low, 2 random grant. abort_at >= 0 asserts
  // reset after that many grants instead of finishing.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gmode, input int hold, input int abort_at);
    logic [2*W-1:0] ea, eb, exp;
    logic [W-1:0]   pa, pb;
    logic           g;
    int             grants, run_cyc;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    exp = ea * eb;
    grants = 0;
    run_cyc = 0;

    check_val("idle_ready", 64'(start_ready), 64'd1);
    op_a = a;
    op_b = b;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);

    while (grants < W && run_cyc < 400) begin
      if (abort_at >= 0 && grants == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      case (gmode)
        0:       g = 1'b1;
        1:       g = run_cyc[0];
        default: g = ($urandom_range(0, 3) != 0);
      endcase
      alu_gnt = g;
      start_valid = 1'($urandom_range(0, 1));
      #1;
      check_val("run_req", 64'(alu_req), 64'd1);
      check_val("run_valid", 64'(result_valid), 64'd0);
      check_val("run_start_ready", 64'(start_ready), 64'd0);
      check_val("run_alu_op", 64'(alu_op), 64'(ALU_ADD));
      pa = alu_in_a;
      pb = alu_in_b;
      @(negedge clk);
      run_cyc++;
      if (g) grants++;
      else begin
        check_val("hold_in_a", 64'(alu_in_a), 64'(pa));
        check_val("hold_in_b", 64'(alu_in_b), 64'(pb));
      end
    end
    start_valid = 1'b0;
    alu_gnt = 1'b0;
    if (run_cyc >= 400) begin
      n_chk++;
      n_err++;
      $display("FAIL run_timeout: got %0d grants expected %0d", grants, W);
    end

    check_val("done_valid", 64'(result_valid), 64'd1);
    check_val("product", 64'(product), 64'(exp));
    check_val("prod_zero", 64'(prod_zero), 64'(exp == '0));
    check_val("prod_wide", 64'(prod_wide), 64'(exp[2*W-1:W] != '0));
    check_val("done_start_ready", 64'(start_ready), 64'd0);
    check_val("done_req", 64'(alu_req), 64'd0);

    for (int i = 0; i < hold; i++) begin
      result_ready = 1'b0;
      start_valid = 1'($urandom_range(0, 1));
      op_a = W'($urandom);
      op_b = W'($urandom);
      @(negedge clk);
      check_val("stall_valid", 64'(result_valid), 64'd1);
      check_val("stall_product", 64'(product), 64'(exp));
      check_val("stall_wide", 64'(prod_wide), 64'(exp[2*W-1:W] != '0));
      check_val("stall_start_ready", 64'(start_ready), 64'd0);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check_val("post_valid", 64'(result_valid), 64'd0);
    check_val("post_start_ready", 64'(start_ready), 64'd1);
    check_val("post_product", 64'(product), 64'd0);
    check_val("post_zero", 64'(prod_zero), 64'd0);
  endtask

  initial begin
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    alu_gnt = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd3, 16'd5, 0, 0, -1);
    run_op(16'hFFFF, 16'hFFFF, 0, 2, -1);
    run_op(16'h0000, 16'h1234, 0, 0, -1);
    run_op(16'h8000, 16'h0000, 0, 1, -1);
    run_op(16'h8000, 16'h0002, 0, 0, -1);
    run_op(16'h00FF, 16'h0101, 1, 0, -1);
    run_op(W'($urandom), W'($urandom), 0, 5, -1);
    run_op(W'($urandom), W'($urandom), 0, 0, 7);
    run_op(16'd7, 16'd9, 0, 0, -1);

    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 4 == 1) ra = ra & 16'h00FF;
      if (k % 4 == 2) rb = rb | 16'h8001;
      run_op(ra, rb, 2, $urandom_range(0, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
